// File: rtl/prng_bit_packer_pkg.sv
// prng_pkg: shared constants, the packer state type and a width helper
// used by prng_bit_packer and prng_word_fifo.
package prng_pkg;

    localparam int PRNG_WORD_W_DEFAULT     = 8;
    localparam int PRNG_FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Smallest number of bits able to index 'value' distinct items (min 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prng_bit_packer_if.sv
// prng_bit_packer_if: valid/ready word stream from the packer to its consumer.
// The packer drives the master side; the consumer (UART TX, LED logic) uses slave.
interface prng_bit_packer_if #(
    parameter int WORD_W = 8
);

    logic [WORD_W-1:0] WORD_DATA;
    logic              WORD_VALID;
    logic              WORD_READY;

    modport master (
        output WORD_DATA,
        output WORD_VALID,
        input  WORD_READY
    );

    modport slave (
        input  WORD_DATA,
        input  WORD_VALID,
        output WORD_READY
    );

endinterface

// File: rtl/prng_bit_packer_word_fifo.sv
// prng_word_fifo: small circular-buffer FIFO with show-ahead read.
// A push while full with no simultaneous pop is dropped and reported on 'drop'.
module prng_word_fifo
    import prng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        drop
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Decide which of push/pop actually take effect this cycle.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
    end

    // Word storage; only written by an accepted push.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/prng_bit_packer.sv
// prng_bit_packer: takes one random bit per BIT_STB pulse while enabled, packs
// WORD_W bits into a word and queues words for a valid/ready consumer.
// Optional build macro PRNG_VON_NEUMANN_EN inserts a von Neumann debiaser
// between the sampled bits and the shift register.
module prng_bit_packer
    import prng_pkg::*;
#(
    parameter int WORD_W     = PRNG_WORD_W_DEFAULT,
    parameter int FIFO_DEPTH = PRNG_FIFO_DEPTH_DEFAULT,
    parameter int MSB_FIRST  = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              EN,
    input  logic                              BIT_STB,
    input  logic                              BIT_IN,
    prng_bit_packer_if.master                 word_bus,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    FILL,
    output logic                              OVERFLOW,
    input  logic                              CLR_OVF
);

    localparam int CNT_W = clog2(WORD_W + 1);

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic                emit_valid;
    logic                emit_bit;
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   shift_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic                word_full;
    logic                push_q;
    logic [WORD_W-1:0]   push_word_q;
    logic [WORD_W-1:0]   fifo_data;
    logic                fifo_empty;
    logic                fifo_drop;
    logic                overflow_q;

    // Enable tracking: COLLECT while EN is high, IDLE otherwise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (EN)  state_d = COLLECT;
            COLLECT: if (!EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept = (state_q == COLLECT) && BIT_STB;

`ifdef PRNG_VON_NEUMANN_EN
    logic phase_q;
    logic first_q;

    // Debiaser pairing: hold the first bit of a pair; leaving COLLECT restarts pairing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= 1'b0;
            first_q <= 1'b0;
        end else if (state_q == IDLE) begin
            phase_q <= 1'b0;
        end else if (accept) begin
            if (!phase_q) begin
                first_q <= BIT_IN;
                phase_q <= 1'b1;
            end else begin
                phase_q <= 1'b0;
            end
        end
    end

    // Pair 10 emits 1 and 01 emits 0, i.e. the first bit whenever the two differ.
    always_comb begin
        emit_valid = accept && phase_q && (first_q != BIT_IN);
        emit_bit   = first_q;
    end
`else
    assign emit_valid = accept;
    assign emit_bit   = BIT_IN;
`endif

    // Shift/count update; a full count wraps to zero in the same cycle a new bit may land.
    always_comb begin
        word_full = (bit_cnt_q == CNT_W'(WORD_W));
        shift_d   = shift_q;
        bit_cnt_d = word_full ? '0 : bit_cnt_q;
        if (emit_valid) begin
            if (MSB_FIRST != 0) begin
                shift_d = {shift_q[WORD_W-2:0], emit_bit};
            end else begin
                shift_d = {emit_bit, shift_q[WORD_W-1:1]};
            end
            bit_cnt_d = bit_cnt_d + CNT_W'(1);
        end
    end

    // Packer registers; a full count captures the completed word into the push stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            push_q    <= word_full;
            if (word_full) begin
                push_word_q <= shift_q;
            end
        end
    end

    prng_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push_q),
        .push_data (push_word_q),
        .pop       (word_bus.WORD_READY),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .count     (FILL),
        .drop      (fifo_drop)
    );

    // Sticky overflow flag; a new drop beats a coincident clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end else if (CLR_OVF) begin
            overflow_q <= 1'b0;
        end
    end

    assign word_bus.WORD_DATA  = fifo_data;
    assign word_bus.WORD_VALID = !fifo_empty;
    assign OVERFLOW            = overflow_q;

endmodule

// File: tb/tb_prng_bit_packer.sv
// tb_prng_bit_packer: drives an MSB-first and an LSB-first packer with the same
// bit stream and compares both against a word-level reference model.
module tb_prng_bit_packer;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic EN = 1'b0;
    logic BIT_STB = 1'b0;
    logic BIT_IN = 1'b0;
    logic WORD_READY = 1'b0;
    logic CLR_OVF = 1'b0;

    logic [2:0] fill_msb;
    logic [2:0] fill_lsb;
    logic       ovf_msb;
    logic       ovf_lsb;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         mbits[$];
    logic [7:0] q_msb[$];
    logic [7:0] q_lsb[$];
    logic       pa_valid, pb_valid;
    logic [7:0] pa_msb, pa_lsb, pb_msb, pb_lsb;
    logic       m_ovf;
    logic       vn_have;
    logic       vn_first;

    always #42 CLK = ~CLK;

    prng_bit_packer_if #(.WORD_W(8)) bus_msb ();
    prng_bit_packer_if #(.WORD_W(8)) bus_lsb ();

    assign bus_msb.WORD_READY = WORD_READY;
    assign bus_lsb.WORD_READY = WORD_READY;

    prng_bit_packer #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_msb (
        .CLK(CLK), .RST(RST), .EN(EN), .BIT_STB(BIT_STB), .BIT_IN(BIT_IN),
        .word_bus(bus_msb), .FILL(fill_msb), .OVERFLOW(ovf_msb), .CLR_OVF(CLR_OVF)
    );

    prng_bit_packer #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .CLK(CLK), .RST(RST), .EN(EN), .BIT_STB(BIT_STB), .BIT_IN(BIT_IN),
        .word_bus(bus_lsb), .FILL(fill_lsb), .OVERFLOW(ovf_lsb), .CLR_OVF(CLR_OVF)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mbits.delete();
        q_msb.delete();
        q_lsb.delete();
        pa_valid = 1'b0; pb_valid = 1'b0;
        pa_msb = '0; pa_lsb = '0; pb_msb = '0; pb_lsb = '0;
        m_ovf = 1'b0;
        vn_have = 1'b0;
        vn_first = 1'b0;
    endtask

    // A packed bit; every eight form one word, first bit = MSB or LSB depending on order.
    task automatic addBit(input bit b);
        mbits.push_back(b);
        if (mbits.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                pa_msb[7-i] = mbits[i];
                pa_lsb[i]   = mbits[i];
            end
            pa_valid = 1'b1;
            mbits.delete();
        end
    endtask

    // One clock edge of the model: a word completed at edge k enters the FIFO at edge k+2.
    task automatic modelEdge(input logic en_c, input logic stb_c, input logic bit_c,
                             input logic rdy_c, input logic clr_c);
        bit do_pop;
        bit do_drop;
        do_pop  = (q_msb.size() != 0) && rdy_c;
        do_drop = pb_valid && (q_msb.size() == 4) && !do_pop;
        if (do_pop) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
        end
        if (pb_valid && !do_drop) begin
            q_msb.push_back(pb_msb);
            q_lsb.push_back(pb_lsb);
        end
        if (do_drop) m_ovf = 1'b1;
        else if (clr_c) m_ovf = 1'b0;
        pb_valid = pa_valid;
        pb_msb   = pa_msb;
        pb_lsb   = pa_lsb;
        pa_valid = 1'b0;
        if (!en_c) vn_have = 1'b0;
        if (en_c && stb_c) begin
`ifdef PRNG_VON_NEUMANN_EN
            if (!vn_have) begin
                vn_first = bit_c;
                vn_have  = 1'b1;
            end else begin
                vn_have = 1'b0;
                if (vn_first != bit_c) addBit(vn_first);
            end
`else
            addBit(bit_c);
`endif
        end
    endtask

    task automatic compareAll();
        checkOutput("valid_msb", 8'(bus_msb.WORD_VALID), 8'(q_msb.size() != 0));
        checkOutput("valid_lsb", 8'(bus_lsb.WORD_VALID), 8'(q_lsb.size() != 0));
        checkOutput("fill_msb", 8'(fill_msb), 8'(q_msb.size()));
        checkOutput("fill_lsb", 8'(fill_lsb), 8'(q_lsb.size()));
        checkOutput("ovf_msb", 8'(ovf_msb), 8'(m_ovf));
        checkOutput("ovf_lsb", 8'(ovf_lsb), 8'(m_ovf));
        if (q_msb.size() != 0) begin
            checkOutput("data_msb", bus_msb.WORD_DATA, q_msb[0]);
            checkOutput("data_lsb", bus_lsb.WORD_DATA, q_lsb[0]);
        end
    endtask

    task automatic tick();
        logic en_c, stb_c, bit_c, rdy_c, clr_c;
        en_c = EN; stb_c = BIT_STB; bit_c = BIT_IN; rdy_c = WORD_READY; clr_c = CLR_OVF;
        @(posedge CLK);
        modelEdge(en_c, stb_c, bit_c, rdy_c, clr_c);
        #1;
        compareAll();
    endtask

    task automatic applyStimulus(input logic en, input logic stb, input logic bi,
                                 input logic rdy, input logic clr);
        EN = en; BIT_STB = stb; BIT_IN = bi; WORD_READY = rdy; CLR_OVF = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(EN, 1'b0, 1'b0, WORD_READY, 1'b0);
    endtask

    task automatic sendBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, 1'b1, bits[i], WORD_READY, 1'b0);
    endtask

    task automatic sendWord(input logic [7:0] w);
        sendBits({24'h0, w}, 8);
    endtask

    // Asynchronous reset in mid-cycle, checked immediately, released after the next edge.
    task automatic resetDut();
        BIT_STB = 1'b0;
        CLR_OVF = 1'b0;
        RST = 1'b1;
        #2;
        modelReset();
        checkOutput("rst_valid_msb", 8'(bus_msb.WORD_VALID), 8'h00);
        checkOutput("rst_valid_lsb", 8'(bus_lsb.WORD_VALID), 8'h00);
        checkOutput("rst_fill_msb", 8'(fill_msb), 8'h00);
        checkOutput("rst_ovf_msb", 8'(ovf_msb), 8'h00);
        checkOutput("rst_data_msb", bus_msb.WORD_DATA, 8'h00);
        checkOutput("rst_data_lsb", bus_lsb.WORD_DATA, 8'h00);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        applyStimulus(EN, 1'b0, 1'b0, WORD_READY, 1'b0);
    endtask

    initial begin
        modelReset();
        #5;

        // Basic packing and push latency
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits(32'b11000001, 8);
        checkOutput("valid_at_strobe", 8'(bus_msb.WORD_VALID), 8'h00);
        idle(1);
        checkOutput("valid_plus1", 8'(bus_msb.WORD_VALID), 8'h00);
        idle(1);
`ifndef PRNG_VON_NEUMANN_EN
        checkOutput("valid_plus2", 8'(bus_msb.WORD_VALID), 8'h01);
        checkOutput("word_c1", bus_msb.WORD_DATA, 8'hC1);
        checkOutput("word_83", bus_lsb.WORD_DATA, 8'h83);
        checkOutput("fill_one", 8'(fill_msb), 8'h01);
`endif

        // Overflow with a stalled consumer, then drain and clear
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int w = 1; w <= 5; w++) sendWord(8'(w));
        idle(3);
`ifndef PRNG_VON_NEUMANN_EN
        checkOutput("full_fill", 8'(fill_msb), 8'h04);
        checkOutput("full_ovf", 8'(ovf_msb), 8'h01);
`endif
        for (int w = 1; w <= 4; w++) begin
`ifndef PRNG_VON_NEUMANN_EN
            checkOutput("drain_a", bus_msb.WORD_DATA, 8'(w));
`endif
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", 8'(ovf_msb), 8'h00);

        // Pop coinciding with the push into a full FIFO
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int w = 1; w <= 5; w++) sendWord(8'(w));
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        WORD_READY = 1'b0;
`ifndef PRNG_VON_NEUMANN_EN
        checkOutput("pushpop_fill", 8'(fill_msb), 8'h04);
        checkOutput("pushpop_ovf", 8'(ovf_msb), 8'h00);
`endif
        for (int w = 2; w <= 5; w++) begin
`ifndef PRNG_VON_NEUMANN_EN
            checkOutput("drain_b", bus_msb.WORD_DATA, 8'(w));
`endif
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // EN gap mid-word: ignored strobes, partial word kept
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits(32'b1011, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits(32'b0010, 4);
        idle(3);
`ifndef PRNG_VON_NEUMANN_EN
        checkOutput("en_gap_word", bus_msb.WORD_DATA, 8'hB2);
        checkOutput("en_gap_fill", 8'(fill_msb), 8'h01);
`endif

        // Reset mid-word: the next word needs a full set of fresh bits
        sendBits(32'b101, 3);
        resetDut();
        sendBits(32'b1100110, 7);
        idle(3);
        checkOutput("after_rst_7bits", 8'(bus_msb.WORD_VALID), 8'h00);
        sendBits(32'b1, 1);
        idle(3);
`ifndef PRNG_VON_NEUMANN_EN
        checkOutput("after_rst_word", bus_msb.WORD_DATA, 8'hCD);
`endif

`ifdef PRNG_VON_NEUMANN_EN
        // Debiaser pairs 01,10,00,11,10,01,10,10,01,01
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits(32'b01100011100110100101, 20);
        idle(3);
        checkOutput("vn_word", bus_msb.WORD_DATA, 8'h6C);
`endif

        // Randomized traffic against the model
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                resetDut();
            end else if ($urandom_range(0, 29) == 0) begin
                applyStimulus(~EN, 1'b0, 1'b0, WORD_READY, 1'b0);
            end else begin
                applyStimulus(EN, ($urandom_range(0, 3) != 0), 1'($urandom),
                              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
